// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int ADDR_BYTES  = 4;
  localparam int COUNT_BYTES = 2;
  localparam int IDX_W       = 2;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word shift assembler; word reflects the byte being
// accepted this cycle so the caller can register a complete word directly.
module byte_to_word
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0]       byte_in,
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      word,
  output logic             word_done
);

  logic [31:0] shift_q, shift_d;

  // New byte enters at the top; after four shifts byte 0 sits in [7:0].
  assign word      = {byte_in, shift_q[31:8]};
  assign word_done = en && (idx == IDX_W'(3));

  always_comb begin
    shift_d = shift_q;
    if (en) shift_d = word;
  end

  always_ff @(posedge clk) begin
    if (reset) shift_q <= '0;
    else       shift_q <= shift_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses {addr, count, words[, checksum]} byte frames, writes
// instruction memory and releases the core. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic [31:0] initial_address,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      init_q, init_d;
  logic             xfer;
  logic [31:0]      word;
  logic             word_done;
  logic [15:0]      n_hdr;
  loader_state_t    tail_st;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  assign tail_st = ST_CHECK;
`else
  assign tail_st = ST_DONE;
`endif

  assign in_ready  = (state_q == ST_ADDR) || (state_q == ST_COUNT) ||
                     (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign xfer      = in_valid && in_ready;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign cpu_reset = (state_q != ST_DONE);
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign initial_address = init_q;
  // Count bytes land in the top half of the assembler after two shifts.
  assign n_hdr = word[31:16];

  byte_to_word u_b2w (
    .clk       (clk),
    .reset     (reset),
    .en        (xfer),
    .byte_in   (in_data),
    .idx       (idx_q),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    init_d      = init_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d = xor_q;
    if (xfer && state_q != ST_CHECK) xor_d = xor_q ^ in_data;
`endif
    if (xfer) begin
      idx_d = idx_q + 1'b1;
      case (state_q)
        ST_ADDR: if (word_done) begin
          init_d  = word;
          addr_d  = word;
          state_d = ST_COUNT;
        end
        ST_COUNT: if (idx_q == IDX_W'(COUNT_BYTES - 1)) begin
          idx_d = '0;
          cnt_d = n_hdr;
          if ({1'b0, n_hdr} > MAX_N) state_d = ST_ERROR;
          else if (n_hdr == 16'd0)   state_d = tail_st;
          else                       state_d = ST_DATA;
        end
        ST_DATA: if (word_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = word;
          addr_d      = addr_q + 32'd4;
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = tail_st;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ADDR;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      init_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      init_q      <= init_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, gaps, wrap, errors, reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic [31:0] initial_address;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [7:0]  tb_xor;
  logic [31:0] log_a [16];
  logic [31:0] log_d [16];
  int nlog = 0;
  int base;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .initial_address(initial_address), .done(done), .error(error)
  );

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (nlog < 16) begin
        log_a[nlog] = mem_addr;
        log_d[nlog] = mem_wdata;
      end
      nlog = nlog + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tb_xor   = tb_xor ^ b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; tb_xor = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Trailing checksum byte, only present in the checksum build.
  task automatic end_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(tb_xor);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; tb_xor = 8'h00;
    idle(); idle();
    reset = 1'b0;

    // reset values
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_cpurst", {31'b0, cpu_reset}, 32'd1);
    chk("rst_init", initial_address, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, error}, 32'd0);

    // basic load, back-to-back
    base = nlog;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    send(8'h13); send(8'h01); send(8'hA0);
    chk("basic_done_early", {31'b0, done}, 32'd0);
    send(8'h00);
    chk("basic_we_lat", {31'b0, mem_we}, 32'd1);
    chk("basic_addr1", mem_addr, 32'h4);
    chk("basic_data1", mem_wdata, 32'h00A00113);
    end_frame();
    chk("basic_done", {31'b0, done}, 32'd1);
    chk("basic_cpurst", {31'b0, cpu_reset}, 32'd0);
    chk("basic_ready", {31'b0, in_ready}, 32'd0);
    idle();
    chk("basic_we_off", {31'b0, mem_we}, 32'd0);
    chk("basic_nwr", nlog - base, 32'd2);
    chk("basic_addr0", log_a[base], 32'h0);
    chk("basic_data0", log_d[base], 32'h00500093);
    chk("basic_init", initial_address, 32'h0);

    // gapped stream
    do_reset();
    base = nlog;
    send(8'h00); idle(); send(8'h01); idle(); send(8'h00); idle(); send(8'h00); idle();
    chk("gap_init", initial_address, 32'h100);
    send(8'h01); idle(); send(8'h00); idle();
    send(8'hEF); idle(); send(8'hBE); idle(); send(8'hAD); idle(); send(8'hDE);
    end_frame();
    chk("gap_done", {31'b0, done}, 32'd1);
    idle();
    chk("gap_nwr", nlog - base, 32'd1);
    chk("gap_addr", log_a[base], 32'h100);
    chk("gap_data", log_d[base], 32'hDEADBEEF);

    // address wrap
    do_reset();
    base = nlog;
    send(8'hFC); send(8'hFF); send(8'hFF); send(8'hFF);
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h11); send(8'h11); send(8'h11);
    send(8'h22); send(8'h22); send(8'h22); send(8'h22);
    end_frame();
    idle();
    chk("wrap_nwr", nlog - base, 32'd2);
    chk("wrap_addr0", log_a[base], 32'hFFFFFFFC);
    chk("wrap_addr1", log_a[base+1], 32'h0);
    chk("wrap_data1", log_d[base+1], 32'h22222222);
    chk("wrap_err", {31'b0, error}, 32'd0);
    chk("wrap_done", {31'b0, done}, 32'd1);

    // zero-length frame
    do_reset();
    base = nlog;
    send(8'h40); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00);
    end_frame();
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_init", initial_address, 32'h40);
    idle();
    chk("zero_nwr", nlog - base, 32'd0);

    // oversize count: 1025
    do_reset();
    base = nlog;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h01); send(8'h04);
    chk("over_err", {31'b0, error}, 32'd1);
    chk("over_cpurst", {31'b0, cpu_reset}, 32'd1);
    chk("over_ready", {31'b0, in_ready}, 32'd0);
    chk("over_done", {31'b0, done}, 32'd0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("over_nwr", nlog - base, 32'd0);

    // reset mid-frame, then a clean reload
    do_reset();
    base = nlog;
    send(8'h00); send(8'h02); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00);
    send(8'h04); send(8'h03); send(8'h02); send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC);
    do_reset();
    chk("mid_we", {31'b0, mem_we}, 32'd0);
    chk("mid_init", initial_address, 32'h0);
    chk("mid_cpurst", {31'b0, cpu_reset}, 32'd1);
    chk("mid_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_addr", mem_addr, 32'h0);
    chk("mid_nwr", nlog - base, 32'd1);
    chk("mid_wr0", log_d[base], 32'h01020304);
    base = nlog;
    send(8'h00); send(8'h03); send(8'h00); send(8'h00);
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    end_frame();
    chk("reload_done", {31'b0, done}, 32'd1);
    idle();
    chk("reload_nwr", nlog - base, 32'd1);
    chk("reload_addr", log_a[base], 32'h300);
    chk("reload_data", log_d[base], 32'h12345678);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // good checksum 0x12
    do_reset();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("ck_wait", {31'b0, done}, 32'd0);
    send(8'h12);
    chk("ck_good", {31'b0, done}, 32'd1);
    // bad checksum 0x13: word still written, core held
    do_reset();
    base = nlog;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13);
    chk("ck_bad_err", {31'b0, error}, 32'd1);
    chk("ck_bad_cpurst", {31'b0, cpu_reset}, 32'd1);
    idle();
    chk("ck_bad_nwr", nlog - base, 32'd1);
    chk("ck_bad_data", log_d[base], 32'h00000013);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
